accum_seq_ctrl: RTL
===================

ACCUM_SEQ_CTRL -- requirements
Module: accum_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 48, SHALL set the complex sample and sum width (upper WIDTH/2 bits imaginary, lower WIDTH/2 bits real).
REQ-002 Parameter CNT_W, default 8, SHALL set the block-length field width.
REQ-003 Parameter PIPE_LAT, default 3, SHALL set the accumulator latency in cycles from acc_data to a settled acc_sum.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to begin one accumulation block; sampled only in IDLE.
REQ-007 len  input  CNT_W  number of samples in the block; latched when start is accepted.
REQ-008 abort  input  1  cancel the current block (active only with ACCUM_CTRL_ABORT_EN).
REQ-009 in_valid / in_ready / in_data  input / output / input WIDTH  sample stream; a transfer occurs when in_valid and in_ready are both 1.
REQ-010 acc_data  output  WIDTH  registered sample to the accumulator input.
REQ-011 acc_clear  output  1  registered accumulator clear (sum-cycle select).
REQ-012 acc_sum  input  WIDTH  accumulator sum output.
REQ-013 res_valid / res_ready / res_data  output / input / output WIDTH  result handshake.
REQ-014 busy, done  output  1 each  busy is 1 outside IDLE; done is a one-cycle completion pulse.

Function
REQ-015 FSM states: IDLE, CLEAR, RUN, DRAIN, HOLD.
REQ-016 IDLE: start=1 with len!=0 SHALL latch len and go to CLEAR; start with len==0 SHALL be ignored.
REQ-017 CLEAR: lasts exactly 1 cycle, drives acc_clear=1 on the following cycle, then goes to RUN.
REQ-018 RUN: in_ready=1; each transfer SHALL put in_data on acc_data on the next cycle; a cycle with no transfer SHALL put acc_data=0.
REQ-019 RUN SHALL count transfers; the transfer that makes the count equal the latched len SHALL cause a move to DRAIN, and in_ready SHALL be 0 from the next cycle.
REQ-020 DRAIN: acc_data=0 for PIPE_LAT+1 cycles; at the end, acc_sum SHALL be captured into res_data, res_valid set to 1, and the FSM goes to HOLD.
REQ-021 HOLD: res_valid and res_data stay stable until res_ready=1; on that handshake, res_valid drops, done pulses for one cycle, and the FSM goes to IDLE.
REQ-022 in_ready SHALL be 0 in every state except RUN, and acc_clear SHALL be 0 except as in REQ-017.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 Gaps in in_valid SHALL stall the count indefinitely without timeout.
REQ-025 res_ready held low SHALL hold HOLD indefinitely.
REQ-026 Block count SHALL range 1..2^CNT_W-1; the counter SHALL NOT wrap within a block.
REQ-027 Throughput: back-to-back blocks SHALL be separated only by the IDLE and CLEAR cycles.

Reset
REQ-028 reset=0 SHALL force IDLE asynchronously in any state, including mid-RUN and mid-DRAIN, discarding partial results.
REQ-029 Reset values: busy, done, in_ready, res_valid, and acc_clear = 0; acc_data, res_data, and internal counters = 0.

Configuration
REQ-030 With ACCUM_CTRL_ABORT_EN defined: abort=1 in any non-IDLE state SHALL return to IDLE next cycle, pulse acc_clear once, drop res_valid, and not pulse done; abort in IDLE SHALL be ignored.
REQ-031 Without ACCUM_CTRL_ABORT_EN: the abort port SHALL exist but be ignored, and behaviour SHALL be per REQ-015..027.

Verification
REQ-032 len=4; samples real 1,2,3,4 and imag 0, back-to-back -> one acc_clear pulse; res_data real=10, imag=0; done one cycle after the res handshake.
REQ-033 len=3; in_valid toggles 1,0,0,1,0,1 -> exactly 3 transfers accepted; zeros are fed in the gaps; in_ready=0 after the 3rd transfer.
REQ-034 res_ready held 0 for 5 cycles in HOLD -> res_valid and res_data are stable for 5 cycles; no done until the handshake; start is ignored meanwhile.
REQ-035 start with len=0 -> busy stays 0; no acc_clear; no res_valid.
REQ-036 With ACCUM_CTRL_ABORT_EN: abort after 2 of 5 samples -> IDLE next cycle; one acc_clear; no res_valid or done. Without the macro: the same stimulus completes normally.
REQ-037 reset asserted during DRAIN -> all outputs go to 0 immediately; after release, a new len=2 block completes correctly.

Source files
------------

// File: rtl/accum_seq_ctrl_if.sv
// accum_seq_ctrl_if: valid/ready/data stream bundle.
// Used for both the sample input and the result output.
interface accum_seq_ctrl_if #(
   parameter int WIDTH = 48
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );
endinterface

// File: rtl/accum_seq_ctrl.sv
// accum_seq_ctrl: sequences one complex accumulation block.
// Optional abort support: define ACCUM_CTRL_ABORT_EN.
module accum_seq_ctrl #(
   parameter int WIDTH    = 48,
   parameter int CNT_W    = 8,
   parameter int PIPE_LAT = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             abort,
   accum_seq_ctrl_if.slave  in_if,
   output logic [WIDTH-1:0] acc_data,
   output logic             acc_clear,
   input  logic [WIDTH-1:0] acc_sum,
   accum_seq_ctrl_if.master res_if,
   output logic             busy,
   output logic             done
);

   localparam int DW = $clog2(PIPE_LAT + 1) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [DW-1:0]    dcnt_q, dcnt_d;
   logic [WIDTH-1:0] acc_data_q, acc_data_d;
   logic             acc_clear_q, acc_clear_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_valid_q, res_valid_d;
   logic             done_q, done_d;

   logic accept;
   logic xfer;
   logic last_xfer;
   logic drain_end;
   logic res_hs;
   logic kill;

   assign accept    = (state_q == S_IDLE) && start
                      && (len != '0);
   assign xfer      = (state_q == S_RUN) && in_if.valid;
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign last_xfer = xfer && (cnt_inc == len_q);
   assign drain_end = (state_q == S_DRAIN)
                      && (dcnt_q == DW'(PIPE_LAT));
   assign res_hs    = (state_q == S_HOLD) && res_if.ready;

`ifdef ACCUM_CTRL_ABORT_EN
   assign kill = abort && (state_q != S_IDLE);
`else
   // abort is present on the port but has no effect here
   assign kill = abort & 1'b0;
`endif

   // state register, cleared asynchronously
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decode; abort overrides every transition
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept)    state_d = S_CLEAR;
         S_CLEAR:                state_d = S_RUN;
         S_RUN:   if (last_xfer) state_d = S_DRAIN;
         S_DRAIN: if (drain_end) state_d = S_HOLD;
         S_HOLD:  if (res_hs)    state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
      if (kill) state_d = S_IDLE;
   end

   // next values of the registered outputs and counters
   always_comb begin
      len_d       = len_q;
      cnt_d       = cnt_q;
      dcnt_d      = dcnt_q;
      acc_data_d  = '0;
      acc_clear_d = 1'b0;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      done_d      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               len_d  = len;
               cnt_d  = '0;
               dcnt_d = '0;
            end
         end
         S_CLEAR: begin
            acc_clear_d = 1'b1;
         end
         S_RUN: begin
            if (xfer) begin
               acc_data_d = in_if.data;
               cnt_d      = cnt_inc;
            end
         end
         S_DRAIN: begin
            dcnt_d = dcnt_q + DW'(1);
            // sum is settled PIPE_LAT cycles after last sample
            if (drain_end) begin
               res_data_d  = acc_sum;
               res_valid_d = 1'b1;
               dcnt_d      = '0;
            end
         end
         S_HOLD: begin
            if (res_hs) begin
               res_valid_d = 1'b0;
               done_d      = 1'b1;
            end
         end
         default: begin
            acc_data_d = '0;
         end
      endcase
      if (kill) begin
         cnt_d       = '0;
         dcnt_d      = '0;
         acc_data_d  = '0;
         acc_clear_d = 1'b1;
         res_valid_d = 1'b0;
         done_d      = 1'b0;
      end
   end

   // datapath and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         len_q       <= '0;
         cnt_q       <= '0;
         dcnt_q      <= '0;
         acc_data_q  <= '0;
         acc_clear_q <= 1'b0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         dcnt_q      <= dcnt_d;
         acc_data_q  <= acc_data_d;
         acc_clear_q <= acc_clear_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         done_q      <= done_d;
      end
   end

   assign acc_data     = acc_data_q;
   assign acc_clear    = acc_clear_q;
   assign res_if.data  = res_data_q;
   assign res_if.valid = res_valid_q;
   assign in_if.ready  = (state_q == S_RUN);
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;

endmodule
